// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads instruction memory combinationally and
// queues {pc, instr} pairs in a small in-order FIFO toward decode.
module instr_fetch #(
   parameter int                ADDR_W   = 7,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                QDEPTH   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_en,
   output logic [ADDR_W-1:0] r_addr_imem,
   input  logic [31:0]       r_data_imem,
   output logic              if_valid,
   output logic [31:0]       if_instr,
   output logic [ADDR_W-1:0] if_pc,
   input  logic              id_ready,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc
);

   localparam int PTR_W = $clog2(QDEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [31:0]       instr;
   } fq_entry_t;

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] redirect_tgt;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;
   fq_entry_t         fq_mem [QDEPTH];
   fq_entry_t         head;
   logic              not_full;
   logic              pop;
   logic              push;

   assign r_addr_imem  = fetch_pc;
   assign redirect_tgt = redirect_pc & WORD_MASK;
   assign not_full     = (count < CNT_W'(QDEPTH));
   assign if_valid     = (count != '0);
   assign pop          = if_valid & id_ready;
   // A full queue can still accept a word when the head leaves the same cycle.
   assign push         = fetch_en & ~redirect_valid & (not_full | pop);

   // Empty queue drives zeros so decode never sees stale entries.
   assign head     = fq_mem[rd_ptr];
   assign if_instr = if_valid ? head.instr : '0;
   assign if_pc    = if_valid ? head.pc    : '0;

   always_ff @(posedge clk) begin
      if (push) fq_mem[wr_ptr] <= {fetch_pc, r_data_imem};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC & WORD_MASK;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else if (redirect_valid) begin
         // Flush: any pop this cycle has already been taken by decode.
         fetch_pc <= redirect_tgt;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            fetch_pc <= fetch_pc + ADDR_W'(4);
            wr_ptr   <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: startup, stall, wrap, redirect, drain, async reset.
module tb_instr_fetch;

   localparam int ADDR_W = 7;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              fetch_en;
   logic [ADDR_W-1:0] r_addr_imem;
   logic [31:0]       r_data_imem;
   logic              if_valid;
   logic [31:0]       if_instr;
   logic [ADDR_W-1:0] if_pc;
   logic              id_ready;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;

   logic [31:0] imem [32];
   int n_checks = 0;
   int n_errors = 0;

   instr_fetch #(.ADDR_W(ADDR_W), .RESET_PC(7'h00), .QDEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
      .r_addr_imem(r_addr_imem), .r_data_imem(r_data_imem),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .id_ready(id_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   assign r_data_imem = imem[r_addr_imem[6:2]];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] word_at(input int addr);
      return (addr == 0) ? 32'h0000_0013 : (addr == 4) ? 32'h0010_0093 : (32'hA000_0000 | 32'(addr >> 2));
   endfunction

   task automatic head_is(input string tag, input int pc);
      chk({tag, "_v"}, 32'(if_valid), 32'd1);
      chk({tag, "_pc"}, 32'(if_pc), 32'(pc));
      chk({tag, "_in"}, if_instr, word_at(pc));
   endtask

   task automatic empty_is(input string tag);
      chk({tag, "_v"}, 32'(if_valid), 32'd0);
      chk({tag, "_pc"}, 32'(if_pc), 32'd0);
      chk({tag, "_in"}, if_instr, 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic redirect_to(input logic [ADDR_W-1:0] tgt);
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
      step();
      redirect_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) imem[i] = word_at(i * 4);
      rst_n = 1'b0; fetch_en = 1'b1; id_ready = 1'b1;
      redirect_valid = 1'b0; redirect_pc = '0;

      // Reset values and first-word latency
      #12;
      empty_is("rst");
      chk("rst_addr", 32'(r_addr_imem), 32'h00);
      rst_n = 1'b1;
      chk("c0_addr", 32'(r_addr_imem), 32'h00);
      chk("c0_v", 32'(if_valid), 32'd0);
      step();
      head_is("c1", 'h00);
      step();
      head_is("c2", 'h04);

      // Stall from reset: queue fills, PC parks at 0x08
      id_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) step();
      head_is("stall", 'h00);
      chk("stall_addr", 32'(r_addr_imem), 32'h08);
      id_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         head_is("drain", k * 4);
         step();
      end

      // PC wrap at top of the address space
      redirect_to(7'h70);
      chk("rd70_v", 32'(if_valid), 32'd0);
      chk("rd70_addr", 32'(r_addr_imem), 32'h70);
      step();
      for (int k = 0; k < 6; k++) begin
         head_is("wrap", (32'h70 + k * 4) & 32'h7C);
         chk("wrap_addr", 32'(r_addr_imem), (32'h74 + k * 4) & 32'h7C);
         step();
      end

      // Full queue, head 0x10, redirect to 0x43 with a pop the same cycle
      id_ready = 1'b0;
      redirect_to(7'h10);
      step(); step();
      head_is("full", 'h10);
      chk("full_addr", 32'(r_addr_imem), 32'h18);
      id_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 7'h43;
      step();
      redirect_valid = 1'b0;
      chk("rd43_v", 32'(if_valid), 32'd0);
      chk("rd43_addr", 32'(r_addr_imem), 32'h40);
      step();
      head_is("rd43_tgt", 'h40);

      // fetch_en=0 drains the queue while the PC holds
      id_ready = 1'b0;
      redirect_to(7'h20);
      step(); step();
      fetch_en = 1'b0;
      id_ready = 1'b1;
      head_is("dr0", 'h20);
      step();
      head_is("dr1", 'h24);
      chk("dr1_addr", 32'(r_addr_imem), 32'h28);
      step();
      empty_is("dr2");
      chk("dr2_addr", 32'(r_addr_imem), 32'h28);
      step();
      chk("dr3_addr", 32'(r_addr_imem), 32'h28);

      // Redirect still applies with fetch_en=0
      redirect_to(7'h50);
      chk("rdoff_addr", 32'(r_addr_imem), 32'h50);
      step();
      chk("rdoff_v", 32'(if_valid), 32'd0);
      chk("rdoff_hold", 32'(r_addr_imem), 32'h50);

      // Back-to-back redirects: last wins
      fetch_en = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 7'h60;
      step();
      redirect_pc = 7'h66;
      step();
      redirect_valid = 1'b0;
      chk("b2b_v", 32'(if_valid), 32'd0);
      chk("b2b_addr", 32'(r_addr_imem), 32'h64);
      step();
      head_is("b2b_tgt", 'h64);

      // Asynchronous reset mid-stream with entries queued
      id_ready = 1'b0;
      step();
      chk("pre_rst_v", 32'(if_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      empty_is("arst");
      chk("arst_addr", 32'(r_addr_imem), 32'h00);
      #2;
      rst_n = 1'b1;
      id_ready = 1'b1;
      step();
      head_is("post_rst", 'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
